// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4 DDR memory tester.
package axi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WA   = 3'd1,
        WD   = 3'd2,
        WB   = 3'd3,
        RA   = 3'd4,
        RD   = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI size encoding: log2 of the beat width in bytes
    function automatic logic [2:0] size_of(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_mem_pattern.sv
// Seeded test pattern: every 32-bit lane of the beat carries addr[31:0] ^ seed.
module axi_mem_pattern #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       seed,
    output logic [DATA_W-1:0] word
);

    logic [31:0] lane_s;

    assign lane_s = 32'(addr) ^ seed;
    assign word   = {(DATA_W / 32){lane_s}};

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 master that writes a seeded pattern over a DDR region, reads it back and
// counts failing beats and bad responses. One transaction outstanding at a time.
module axi_mem_tester
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [CNT_W-1:0]      num_bursts,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int BEAT_BYTES  = DATA_W / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t                state_r, state_next_s;
    logic [ADDR_W-1:0]     base_r, cur_r;
    logic [31:0]           seed_r;
    logic [CNT_W-1:0]      num_r, left_r;
    logic [BEAT_W-1:0]     wbeat_r, rbeat_r;
    logic [CNT_W-1:0]      err_count_r;
    logic [ADDR_W-1:0]     first_err_r;
    logic                  busy_r, done_r;
    logic [ADDR_W-1:0]     wr_addr_s, rd_addr_s, err_addr_s;
    logic [DATA_W-1:0]     wr_word_s, rd_word_s;
    logic                  last_burst_s, err_s;

    assign wr_addr_s    = cur_r + ADDR_W'(wbeat_r) * ADDR_W'(BEAT_BYTES);
    assign rd_addr_s    = cur_r + ADDR_W'(rbeat_r) * ADDR_W'(BEAT_BYTES);
    assign last_burst_s = (left_r == CNT_W'(1));

    axi_mem_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pattern (
        .addr (wr_addr_s),
        .seed (seed_r),
        .word (wr_word_s)
    );

    axi_mem_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_pattern (
        .addr (rd_addr_s),
        .seed (seed_r),
        .word (rd_word_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (num_bursts == '0) ? DONE : WA;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WA: begin
                if (m_axi_awready) state_next_s = WD;
                else               state_next_s = WA;
            end
            WD: begin
                if (m_axi_wready && (wbeat_r == LAST_BEAT)) state_next_s = WB;
                else                                        state_next_s = WD;
            end
            WB: begin
                if (m_axi_bvalid) state_next_s = last_burst_s ? RA : WA;
                else              state_next_s = WB;
            end
            RA: begin
                if (m_axi_arready) state_next_s = RD;
                else               state_next_s = RA;
            end
            RD: begin
                if (m_axi_rvalid && (rbeat_r == LAST_BEAT)) state_next_s = last_burst_s ? DONE : RA;
                else                                        state_next_s = RD;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // A beat fails on data, response or a misplaced rlast; a write fails on bresp
    always_comb begin
        err_s      = 1'b0;
        err_addr_s = cur_r;
        if ((state_r == WB) && m_axi_bvalid) begin
            err_s      = (m_axi_bresp != AXI_RESP_OKAY);
            err_addr_s = cur_r;
        end else if ((state_r == RD) && m_axi_rvalid) begin
            err_s      = (m_axi_rdata != rd_word_s) || (m_axi_rresp != AXI_RESP_OKAY) ||
                         (m_axi_rlast != (rbeat_r == LAST_BEAT));
            err_addr_s = rd_addr_s;
        end else begin
            err_s      = 1'b0;
            err_addr_s = cur_r;
        end
    end

    // Run context: latched inputs, current burst address, beat and burst counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r  <= '0;
            cur_r   <= '0;
            seed_r  <= 32'd0;
            num_r   <= '0;
            left_r  <= '0;
            wbeat_r <= '0;
            rbeat_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        base_r  <= base_addr;
                        cur_r   <= base_addr;
                        seed_r  <= seed;
                        num_r   <= num_bursts;
                        left_r  <= num_bursts;
                        wbeat_r <= '0;
                        rbeat_r <= '0;
                    end
                end
                WD: begin
                    if (m_axi_wready) begin
                        wbeat_r <= (wbeat_r == LAST_BEAT) ? '0 : wbeat_r + BEAT_W'(1);
                    end
                end
                WB: begin
                    if (m_axi_bvalid) begin
                        // Read phase restarts from the region base with the full count
                        if (last_burst_s) begin
                            cur_r  <= base_r;
                            left_r <= num_r;
                        end else begin
                            cur_r  <= cur_r + ADDR_W'(BURST_BYTES);
                            left_r <= left_r - CNT_W'(1);
                        end
                    end
                end
                RD: begin
                    if (m_axi_rvalid) begin
                        if (rbeat_r == LAST_BEAT) begin
                            rbeat_r <= '0;
                            cur_r   <= cur_r + ADDR_W'(BURST_BYTES);
                            left_r  <= left_r - CNT_W'(1);
                        end else begin
                            rbeat_r <= rbeat_r + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating error counter and first-failure capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_r <= '0;
            first_err_r <= '0;
        end else if ((state_r == IDLE) && start) begin
            err_count_r <= '0;
            first_err_r <= '0;
        end else if (err_s && (err_count_r != '1)) begin
            err_count_r <= err_count_r + CNT_W'(1);
            if (err_count_r == '0) begin
                first_err_r <= err_addr_s;
            end
        end
    end

    // Run status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == DONE);
            if ((state_r == IDLE) && start) begin
                busy_r <= 1'b1;
            end else if (state_r == DONE) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign err_count      = err_count_r;
    assign first_err_addr = first_err_r;

    assign m_axi_awaddr  = cur_r;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = size_of(DATA_W);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = (state_r == WA);
    assign m_axi_wdata   = wr_word_s;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state_r == WD) && (wbeat_r == LAST_BEAT);
    assign m_axi_wvalid  = (state_r == WD);
    assign m_axi_bready  = (state_r == WB);
    assign m_axi_araddr  = cur_r;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = size_of(DATA_W);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (state_r == RA);
    assign m_axi_rready  = (state_r == RD);

endmodule

// File: tb/tb_axi_mem_tester.sv
// Scoreboard bench for axi_mem_tester: a memory-backed AXI slave model with
// fault injection, expected transfers queued at start and popped by the monitor.
module tb_axi_mem_tester;

    localparam int ADDR_W = 32, DATA_W = 128, BURST_LEN = 16, CNT_W = 16;
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0] num_bursts = '0;
    logic [31:0] seed = '0;
    logic busy, done;
    logic [CNT_W-1:0] err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst;
    logic awvalid, wvalid, wlast, bready, arvalid, rready;
    logic awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [1:0] bresp = 2'b00, rresp = 2'b00;
    logic bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [DATA_W-1:0] rdata = '0;

    axi_mem_tester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .seed(seed), .busy(busy), .done(done),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    // Scoreboard queues
    logic [31:0]  aw_exp[$], ar_exp[$];
    logic [127:0] w_exp[$];
    int           err_exp_q[$];
    logic [31:0]  ferr_exp_q[$];
    bit           ferr_chk_q[$];

    // Slave configuration and state
    bit          bp = 1'b0, flip_en = 1'b0;
    logic [31:0] flip_addr = '0;
    int          bresp_burst = -1, rlast_burst = -1;
    logic [127:0] mem [bit [31:0]];
    logic [31:0] wr_bursts[$], r_bursts[$];
    int  b_pending = 0, b_idx = 0, r_beat = 0, r_idx = 0, w_beat = 0, w_hs = 0;
    bit  b_fire = 0, r_fire = 0, aw_stall = 0, w_stall = 0, done_seen = 0, any_valid = 0;
    logic [31:0]  aw_prev;
    logic [127:0] w_prev;

    function automatic logic [127:0] pat(input logic [31:0] a, input logic [31:0] s);
        return {4{a ^ s}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit go();
        return bp ? bit'($urandom_range(1, 0)) : 1'b1;
    endfunction

    // Slave model plus monitor, evaluated once per cycle on the falling edge
    task automatic slave_step();
        logic [31:0] a, e;
        logic [127:0] d;
        if (done) begin
            done_seen = 1;
            check("done_expected", err_exp_q.size() != 0, 1);
            if (err_exp_q.size() != 0) begin
                check("err_count", err_count, err_exp_q.pop_front());
                e = ferr_exp_q.pop_front();
                if (ferr_chk_q.pop_front()) check("first_err_addr", first_err_addr, e);
            end
        end
        if (awvalid || wvalid || arvalid) any_valid = 1;
        if (aw_stall) check("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev});
        if (w_stall) check("w_hold", {wvalid, wdata}, {1'b1, w_prev});
        // B channel
        if (b_fire) begin
            bvalid = 0; b_fire = 0; b_pending--; b_idx++;
        end
        if (!bvalid && b_pending > 0 && go()) begin
            bvalid = 1;
            bresp = (b_idx == bresp_burst) ? 2'b10 : 2'b00;
        end
        b_fire = bvalid && bready;
        // R channel
        if (r_fire) begin
            rvalid = 0; r_fire = 0; r_beat++;
            if (r_beat == BURST_LEN) begin
                r_beat = 0; void'(r_bursts.pop_front()); r_idx++;
            end
        end
        if (!rvalid && r_bursts.size() > 0 && go()) begin
            a = r_bursts[0] + 32'(r_beat * BEAT_BYTES);
            d = mem.exists(a) ? mem[a] : '0;
            if (flip_en && a == flip_addr) d[0] = ~d[0];
            rdata = d; rresp = 2'b00;
            rlast = (r_beat == BURST_LEN - 1) && (r_idx != rlast_burst);
            rvalid = 1;
        end
        r_fire = rvalid && rready;
        // AW channel
        awready = go();
        if (awvalid && awready) begin
            check("aw_expected", aw_exp.size() != 0, 1);
            if (aw_exp.size() != 0) check("awaddr", awaddr, aw_exp.pop_front());
            check("aw_ctl", {awlen, awsize, awburst}, {8'd15, 3'd4, 2'b01});
            wr_bursts.push_back(awaddr);
        end
        aw_stall = awvalid && !awready; aw_prev = awaddr;
        // W channel
        wready = go();
        if (wvalid && wready) begin
            check("w_expected", w_exp.size() != 0, 1);
            if (w_exp.size() != 0) check("wdata", wdata, w_exp.pop_front());
            check("wstrb", wstrb, 16'hFFFF);
            check("wlast", wlast, w_beat == BURST_LEN - 1);
            if (wr_bursts.size() != 0) mem[wr_bursts[0] + 32'(w_beat * BEAT_BYTES)] = wdata;
            w_hs++; w_beat++;
            if (w_beat == BURST_LEN) begin
                w_beat = 0; void'(wr_bursts.pop_front()); b_pending++;
            end
        end
        w_stall = wvalid && !wready; w_prev = wdata;
        // AR channel
        arready = go();
        if (arvalid && arready) begin
            check("ar_expected", ar_exp.size() != 0, 1);
            if (ar_exp.size() != 0) check("araddr", araddr, ar_exp.pop_front());
            check("ar_ctl", {arlen, arsize, arburst}, {8'd15, 3'd4, 2'b01});
            r_bursts.push_back(araddr);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) slave_step();
        end
    end

    task automatic flush();
        aw_exp.delete(); ar_exp.delete(); w_exp.delete();
        err_exp_q.delete(); ferr_exp_q.delete(); ferr_chk_q.delete();
        wr_bursts.delete(); r_bursts.delete();
        b_pending = 0; b_idx = 0; r_beat = 0; r_idx = 0; w_beat = 0;
        b_fire = 0; r_fire = 0; aw_stall = 0; w_stall = 0;
        bvalid = 0; rvalid = 0; rlast = 0;
    endtask

    // Reference model: the whole run's expected traffic and final result
    task automatic expect_run(input logic [31:0] base, input int n, input logic [31:0] sd);
        int e = 0;
        bit flip_hit;
        for (int b = 0; b < n; b++) begin
            aw_exp.push_back(base + 32'(b * BURST_BYTES));
            ar_exp.push_back(base + 32'(b * BURST_BYTES));
            for (int k = 0; k < BURST_LEN; k++)
                w_exp.push_back(pat(base + 32'(b * BURST_BYTES + k * BEAT_BYTES), sd));
        end
        flip_hit = flip_en && (flip_addr - base) < 32'(n * BURST_BYTES);
        if (bresp_burst >= 0 && bresp_burst < n) e++;
        if (rlast_burst >= 0 && rlast_burst < n) e++;
        if (flip_hit) e++;
        err_exp_q.push_back(e);
        ferr_exp_q.push_back(flip_addr);
        ferr_chk_q.push_back(flip_hit && e == 1);
        b_idx = 0; r_idx = 0;
    endtask

    task automatic pulse_start(input logic [31:0] base, input int n, input logic [31:0] sd);
        done_seen = 0;
        @(negedge clk);
        base_addr = base; num_bursts = CNT_W'(n); seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = $urandom; num_bursts = CNT_W'($urandom); seed = $urandom;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        while (!done_seen && c < budget) begin
            @(posedge clk);
            c++;
        end
        check({name, "_done"}, done_seen, 1);
        @(negedge clk);
        check({name, "_busy"}, busy, 0);
        check({name, "_aw_left"}, aw_exp.size(), 0);
        check({name, "_w_left"}, w_exp.size(), 0);
        check({name, "_ar_left"}, ar_exp.size(), 0);
    endtask

    task automatic run(input string name, input logic [31:0] base, input int n,
                       input logic [31:0] sd, input int budget);
        expect_run(base, n, sd);
        pulse_start(base, n, sd);
        wait_done(name, budget);
    endtask

    initial begin
        logic [31:0] sd;
        repeat (3) @(negedge clk);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_err", {err_count, first_err_addr}, 48'd0);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: ideal slave, 4 bursts
        run("t1", 32'h1000_0000, 4, 32'hA5A5_0000, 2000);

        // 2: empty run, done two cycles after start, no traffic
        any_valid = 0;
        expect_run(32'h1000_0000, 0, 32'h1234_5678);
        done_seen = 0;
        @(negedge clk);
        base_addr = 32'h1000_0000; num_bursts = '0; seed = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t2_done_1cyc", done, 0);
        @(negedge clk);
        check("t2_done_2cyc", done, 1);
        wait_done("t2", 50);
        check("t2_no_valid", any_valid, 0);

        // 3: single flipped read bit
        flip_en = 1; flip_addr = 32'h1000_0130;
        run("t3", 32'h1000_0000, 4, $urandom, 2000);
        flip_en = 0;

        // 4: random backpressure on every channel
        bp = 1;
        sd = $urandom;
        run("t4", 32'h2000_0000 + ($urandom & 32'h00FF_FF00), 32, sd, 20000);
        bp = 0;

        // 5: SLVERR on burst 2, missing rlast on burst 3
        bresp_burst = 2; rlast_burst = 3;
        run("t5", 32'h1000_0000, 4, $urandom, 2000);
        bresp_burst = -1; rlast_burst = -1;

        // 6: asynchronous reset in the middle of the write data phase
        w_hs = 0;
        expect_run(32'h3000_0000, 4, 32'hDEAD_BEEF);
        pulse_start(32'h3000_0000, 4, 32'hDEAD_BEEF);
        begin
            int c = 0;
            while (w_hs < 7 && c < 500) begin
                @(posedge clk);
                c++;
            end
            check("t6_reached_wd", w_hs >= 7, 1);
        end
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
        check("t6_rst_busy", {busy, done}, 2'b00);
        check("t6_rst_err", err_count, 0);
        flush();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run("t6_rerun", 32'h3000_0000, 2, $urandom, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
